conv_pixel_scheduler: RTL and testbench

- Sequences one convolution layer pass on the MAC datapath: RAM read enables, address-generator advance, input-memory group select, accumulator sload and MAC enable.
- Emits one tagged result strobe per output pixel, then a one-cycle layer_done.
- Started by a one-cycle start_req from the layer-level control. It replaces free-running enable-derived timing with an explicit FSM so layers can be re-launched without reset.

---
 rtl/conv_sched_pkg.sv | 37 +++
 rtl/sched_delay_line.sv | 27 ++
 rtl/conv_pixel_scheduler.sv | 181 ++++++++++++++++++
 tb/tb_conv_pixel_scheduler.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_sched_pkg.sv
// Shared definitions for the convolution pixel scheduler: FSM states,
// default-configuration derived sizes and a width helper.
package conv_sched_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_PRIME = 3'd1,
        S_ACCUM = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } sched_state_e;

    function automatic int unsigned sched_clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(n)) r = i + 1;
        end
        return r;
    endfunction

    // Register width able to hold n-1, never narrower than one bit.
    function automatic int unsigned sched_width(input int unsigned n);
        return (n > 1) ? sched_clog2(n) : 1;
    endfunction

    localparam int unsigned DEF_W      = 8;
    localparam int unsigned DEF_H      = 8;
    localparam int unsigned DEF_M      = 1;
    localparam int unsigned DEF_INTER  = 9;
    localparam int unsigned DEF_GROUPS = 2;
    localparam int unsigned DEF_CYC    = DEF_INTER * DEF_GROUPS;
    localparam int unsigned DEF_P      = DEF_W * DEF_H * DEF_M;
    localparam int unsigned DEF_PW     = sched_width(DEF_P);
    localparam int unsigned DEF_GW     = sched_width(DEF_GROUPS);

endpackage

// File: rtl/sched_delay_line.sv
// Fixed-depth register delay line with asynchronous active-low clear.
module sched_delay_line
    import conv_sched_pkg::*;
#(
    parameter int unsigned DEPTH = 1,
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] pipe_q [DEPTH];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < DEPTH; i++) pipe_q[i] <= '0;
        end else begin
            pipe_q[0] <= d_i;
            for (int unsigned i = 1; i < DEPTH; i++) pipe_q[i] <= pipe_q[i-1];
        end
    end

    assign q_o = pipe_q[DEPTH-1];

endmodule

// File: rtl/conv_pixel_scheduler.sv
// Layer-pass sequencer for the MAC datapath: prime the RAM pipeline, accumulate
// every output pixel over all input-memory groups, drain the MAC, flag done.
module conv_pixel_scheduler
    import conv_sched_pkg::*;
#(
    parameter int unsigned OUT_FEATURE_WIDTH_W       = 8,
    parameter int unsigned OUT_FEATURE_WIDTH_H       = 8,
    parameter int unsigned NUM_ONEMULT               = 1,
    parameter int unsigned NUM_ONE_PIXEL_CYCLE_INTER = 9,
    parameter int unsigned IFMAP_GROUPS              = 2,
    parameter int unsigned RD_LATENCY                = 2,
    parameter int unsigned MAC_LATENCY               = 1
) (
    input  logic clock,
    input  logic reset,
    input  logic start_req,
    output logic busy,
    output logic rden,
    output logic addr_en,
    output logic [sched_width(IFMAP_GROUPS)-1:0] group_sel,
    output logic accum_sload,
    output logic mult_en,
    output logic result_valid,
    output logic [sched_width(OUT_FEATURE_WIDTH_W*OUT_FEATURE_WIDTH_H*NUM_ONEMULT)-1:0] result_idx,
    output logic layer_done
);

    localparam int unsigned CYC  = NUM_ONE_PIXEL_CYCLE_INTER * IFMAP_GROUPS;
    localparam int unsigned P    = OUT_FEATURE_WIDTH_W * OUT_FEATURE_WIDTH_H * NUM_ONEMULT;
    localparam int unsigned PW   = sched_width(P);
    localparam int unsigned GW   = sched_width(IFMAP_GROUPS);
    localparam int unsigned CW   = sched_width(CYC);
    localparam int unsigned IW   = sched_width(NUM_ONE_PIXEL_CYCLE_INTER);
    localparam int unsigned WMAX = (RD_LATENCY > MAC_LATENCY) ? RD_LATENCY : MAC_LATENCY;
    localparam int unsigned WW   = sched_width(WMAX);
    localparam int unsigned XW   = sched_width(P * CYC + 1);

    localparam logic [CW-1:0] CYC_LAST    = CW'(CYC - 1);
    localparam logic [IW-1:0] INTER_LAST  = IW'(NUM_ONE_PIXEL_CYCLE_INTER - 1);
    localparam logic [PW-1:0] PIX_LAST    = PW'(P - 1);
    localparam logic [WW-1:0] PRIME_LAST  = WW'(RD_LATENCY - 1);
    localparam logic [WW-1:0] DRAIN_LAST  = WW'(MAC_LATENCY - 1);
    localparam logic [XW-1:0] ISSUE_TOTAL = XW'(P * CYC);

    sched_state_e  state_q, state_d;
    logic [CW-1:0] cyc_q,   cyc_d;
    logic [IW-1:0] inter_q, inter_d;
    logic [GW-1:0] grp_q,   grp_d;
    logic [PW-1:0] pix_q,   pix_d;
    logic [WW-1:0] wait_q,  wait_d;
    logic [XW-1:0] issue_q, issue_d;
    logic          last_acc;
    logic [PW:0]   strobe_in, strobe_out;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cyc_q   <= '0;
            inter_q <= '0;
            grp_q   <= '0;
            pix_q   <= '0;
            wait_q  <= '0;
            issue_q <= '0;
        end else begin
            state_q <= state_d;
            cyc_q   <= cyc_d;
            inter_q <= inter_d;
            grp_q   <= grp_d;
            pix_q   <= pix_d;
            wait_q  <= wait_d;
            issue_q <= issue_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cyc_d       = cyc_q;
        inter_d     = inter_q;
        grp_d       = grp_q;
        pix_d       = pix_q;
        wait_d      = wait_q;
        issue_d     = issue_q;
        busy        = 1'b0;
        rden        = 1'b0;
        addr_en     = 1'b0;
        group_sel   = '0;
        accum_sload = 1'b0;
        mult_en     = 1'b0;
        layer_done  = 1'b0;
        last_acc    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start_req) begin
                    state_d = S_PRIME;
                    cyc_d   = '0;
                    inter_d = '0;
                    grp_d   = '0;
                    pix_d   = '0;
                    wait_d  = '0;
                    issue_d = '0;
                end
            end
            S_PRIME: begin
                busy = 1'b1;
                if (issue_q != ISSUE_TOTAL) begin
                    rden    = 1'b1;
                    addr_en = 1'b1;
                    issue_d = issue_q + 1'b1;
                end
                if (wait_q == PRIME_LAST) begin
                    wait_d  = '0;
                    state_d = S_ACCUM;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            S_ACCUM: begin
                busy        = 1'b1;
                mult_en     = 1'b1;
                group_sel   = grp_q;
                accum_sload = (cyc_q == '0);
                // Address issue stops once the whole layer has been fetched, so the
                // final RD_LATENCY accumulate cycles consume already-requested data.
                if (issue_q != ISSUE_TOTAL) begin
                    rden    = 1'b1;
                    addr_en = 1'b1;
                    issue_d = issue_q + 1'b1;
                end
                if (inter_q == INTER_LAST) begin
                    inter_d = '0;
                    grp_d   = grp_q + 1'b1;
                end else begin
                    inter_d = inter_q + 1'b1;
                end
                if (cyc_q == CYC_LAST) begin
                    last_acc = 1'b1;
                    cyc_d    = '0;
                    inter_d  = '0;
                    grp_d    = '0;
                    if (pix_q == PIX_LAST) state_d = S_DRAIN;
                    else                   pix_d   = pix_q + 1'b1;
                end else begin
                    cyc_d = cyc_q + 1'b1;
                end
            end
            S_DRAIN: begin
                busy    = 1'b1;
                mult_en = 1'b1;
                if (wait_q == DRAIN_LAST) begin
                    wait_d  = '0;
                    state_d = S_DONE;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            S_DONE: begin
                busy       = 1'b1;
                layer_done = 1'b1;
                state_d    = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign strobe_in = {last_acc, last_acc ? pix_q : '0};

    sched_delay_line #(
        .DEPTH (MAC_LATENCY),
        .WIDTH (PW + 1)
    ) u_result_dly (
        .clk_i  (clock),
        .rst_ni (reset),
        .d_i    (strobe_in),
        .q_o    (strobe_out)
    );

    assign result_valid = strobe_out[PW];
    assign result_idx   = strobe_out[PW-1:0];

endmodule

// File: tb/tb_conv_pixel_scheduler.sv
// Bench for conv_pixel_scheduler: four configurations side by side, checked
// cycle by cycle against a closed-form timing model of one layer pass.
module tb_conv_pixel_scheduler;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    logic start_s [4];
    logic busy_s  [4];
    logic rden_s  [4];
    logic aen_s   [4];
    logic sload_s [4];
    logic mult_s  [4];
    logic rv_s    [4];
    logic done_s  [4];
    logic [0:0] gsel_a, gsel_b, gsel_c;
    logic [1:0] gsel_d;
    logic [1:0] ridx_a;
    logic [0:0] ridx_b;
    logic [3:0] ridx_c;
    logic [0:0] ridx_d;

    typedef struct packed {
        logic [31:0] busy, rden, aen, gsel, sload, mult, rv, ridx, done;
    } out_t;

    int   vectors = 0;
    int   miscompares = 0;
    int   tcyc = 0;
    int   st [4];
    bit   act [4];
    int   aen_cnt [4];
    int   rv_cnt [4];
    int   done_cnt [4];
    int   a_idx [$];

    // A: plan config (P=4, CYC=6)
    conv_pixel_scheduler #(
        .OUT_FEATURE_WIDTH_W(2), .OUT_FEATURE_WIDTH_H(2), .NUM_ONEMULT(1),
        .NUM_ONE_PIXEL_CYCLE_INTER(3), .IFMAP_GROUPS(2), .RD_LATENCY(2), .MAC_LATENCY(1)
    ) u_a (
        .clock(clock), .reset(reset), .start_req(start_s[0]), .busy(busy_s[0]),
        .rden(rden_s[0]), .addr_en(aen_s[0]), .group_sel(gsel_a), .accum_sload(sload_s[0]),
        .mult_en(mult_s[0]), .result_valid(rv_s[0]), .result_idx(ridx_a), .layer_done(done_s[0])
    );

    // B: degenerate single pixel, single cycle
    conv_pixel_scheduler #(
        .OUT_FEATURE_WIDTH_W(1), .OUT_FEATURE_WIDTH_H(1), .NUM_ONEMULT(1),
        .NUM_ONE_PIXEL_CYCLE_INTER(1), .IFMAP_GROUPS(1), .RD_LATENCY(1), .MAC_LATENCY(1)
    ) u_b (
        .clock(clock), .reset(reset), .start_req(start_s[1]), .busy(busy_s[1]),
        .rden(rden_s[1]), .addr_en(aen_s[1]), .group_sel(gsel_b), .accum_sload(sload_s[1]),
        .mult_en(mult_s[1]), .result_valid(rv_s[1]), .result_idx(ridx_b), .layer_done(done_s[1])
    );

    // C: P=12 for back-to-back launches
    conv_pixel_scheduler #(
        .OUT_FEATURE_WIDTH_W(3), .OUT_FEATURE_WIDTH_H(2), .NUM_ONEMULT(2),
        .NUM_ONE_PIXEL_CYCLE_INTER(3), .IFMAP_GROUPS(2), .RD_LATENCY(2), .MAC_LATENCY(1)
    ) u_c (
        .clock(clock), .reset(reset), .start_req(start_s[2]), .busy(busy_s[2]),
        .rden(rden_s[2]), .addr_en(aen_s[2]), .group_sel(gsel_c), .accum_sload(sload_s[2]),
        .mult_en(mult_s[2]), .result_valid(rv_s[2]), .result_idx(ridx_c), .layer_done(done_s[2])
    );

    // D: three groups, longer read and MAC latencies
    conv_pixel_scheduler #(
        .OUT_FEATURE_WIDTH_W(2), .OUT_FEATURE_WIDTH_H(1), .NUM_ONEMULT(1),
        .NUM_ONE_PIXEL_CYCLE_INTER(2), .IFMAP_GROUPS(3), .RD_LATENCY(3), .MAC_LATENCY(2)
    ) u_d (
        .clock(clock), .reset(reset), .start_req(start_s[3]), .busy(busy_s[3]),
        .rden(rden_s[3]), .addr_en(aen_s[3]), .group_sel(gsel_d), .accum_sload(sload_s[3]),
        .mult_en(mult_s[3]), .result_valid(rv_s[3]), .result_idx(ridx_d), .layer_done(done_s[3])
    );

    // Expected outputs k cycles after an accepted start, from the layer timing rules.
    function automatic out_t model(int rd, int inter, int groups, int p, int mac, bit a, int k);
        out_t e;
        int cyc, acc0, accn, last, j, c;
        e    = '0;
        cyc  = inter * groups;
        acc0 = rd + 1;
        accn = rd + p * cyc;
        last = accn + mac + 1;
        if (!a || k < 1 || k > last) return e;
        e.busy = 1;
        e.aen  = (k <= p * cyc) ? 1 : 0;
        e.rden = e.aen;
        if (k >= acc0 && k <= accn) begin
            c       = (k - acc0) % cyc;
            e.sload = (c == 0) ? 1 : 0;
            e.gsel  = 32'(c / inter);
        end
        e.mult = (k >= acc0 && k <= accn + mac) ? 1 : 0;
        j = k - mac;
        if (j >= acc0 && j <= accn && (j - acc0) % cyc == cyc - 1) begin
            e.rv   = 1;
            e.ridx = 32'((j - acc0) / cyc);
        end
        e.done = (k == last) ? 1 : 0;
        return e;
    endfunction

    function automatic out_t model_of(int i, bit a, int k);
        case (i)
            0:       return model(2, 3, 2, 4, 1, a, k);
            1:       return model(1, 1, 1, 1, 1, a, k);
            2:       return model(2, 3, 2, 12, 1, a, k);
            default: return model(3, 2, 3, 2, 2, a, k);
        endcase
    endfunction

    function automatic int done_k(int i);
        case (i)
            0:       return 2 + 24 + 1 + 1;
            1:       return 1 + 1 + 1 + 1;
            2:       return 2 + 72 + 1 + 1;
            default: return 3 + 12 + 2 + 1;
        endcase
    endfunction

    function automatic out_t gather(int i);
        out_t o;
        o.busy  = 32'(busy_s[i]);
        o.rden  = 32'(rden_s[i]);
        o.aen   = 32'(aen_s[i]);
        o.sload = 32'(sload_s[i]);
        o.mult  = 32'(mult_s[i]);
        o.rv    = 32'(rv_s[i]);
        o.done  = 32'(done_s[i]);
        case (i)
            0:       begin o.gsel = 32'(gsel_a); o.ridx = 32'(ridx_a); end
            1:       begin o.gsel = 32'(gsel_b); o.ridx = 32'(ridx_b); end
            2:       begin o.gsel = 32'(gsel_c); o.ridx = 32'(ridx_c); end
            default: begin o.gsel = 32'(gsel_d); o.ridx = 32'(ridx_d); end
        endcase
        return o;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        vectors++;
        assert (got === want) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, want);
        end
    endtask

    task automatic check(input int i, input out_t o, input out_t e);
        string t;
        t = $sformatf("%s@%0d", (i == 0) ? "A" : (i == 1) ? "B" : (i == 2) ? "C" : "D", tcyc);
        chk({t, ".busy"},  o.busy,  e.busy);
        chk({t, ".rden"},  o.rden,  e.rden);
        chk({t, ".addr_en"}, o.aen, e.aen);
        chk({t, ".group_sel"}, o.gsel, e.gsel);
        chk({t, ".accum_sload"}, o.sload, e.sload);
        chk({t, ".mult_en"}, o.mult, e.mult);
        chk({t, ".result_valid"}, o.rv, e.rv);
        chk({t, ".result_idx"}, o.ridx, e.ridx);
        chk({t, ".layer_done"}, o.done, e.done);
    endtask

    task automatic clear_counts();
        for (int i = 0; i < 4; i++) begin
            aen_cnt[i]  = 0;
            rv_cnt[i]   = 0;
            done_cnt[i] = 0;
        end
        a_idx.delete();
    endtask

    // One clock cycle: drive starts, compare at the falling edge, update the model.
    task automatic tick(input logic [3:0] s);
        out_t o;
        for (int i = 0; i < 4; i++) start_s[i] = s[i];
        @(negedge clock);
        for (int i = 0; i < 4; i++) begin
            o = gather(i);
            check(i, o, model_of(i, act[i], tcyc - st[i]));
            if (o.aen === 32'd1)  aen_cnt[i]++;
            if (o.rv === 32'd1)   rv_cnt[i]++;
            if (o.done === 32'd1) done_cnt[i]++;
            if (i == 0 && o.rv === 32'd1) a_idx.push_back(int'(o.ridx));
        end
        for (int i = 0; i < 4; i++) begin
            if (s[i] && (!act[i] || (tcyc - st[i]) > done_k(i))) begin
                act[i] = 1'b1;
                st[i]  = tcyc;
            end
        end
        @(posedge clock);
        tcyc++;
        #1;
        for (int i = 0; i < 4; i++) start_s[i] = 1'b0;
    endtask

    // Reset pulse starting mid-cycle; outputs must clear before the next edge.
    task automatic rst_tick();
        reset = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) check(i, gather(i), '0);
        for (int i = 0; i < 4; i++) act[i] = 1'b0;
        @(negedge clock);
        for (int i = 0; i < 4; i++) check(i, gather(i), model_of(i, act[i], 0));
        @(posedge clock);
        tcyc++;
        #1;
        reset = 1'b1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] s;
        for (int i = 0; i < 4; i++) begin
            start_s[i] = 1'b0;
            act[i]     = 1'b0;
            st[i]      = 0;
        end
        #1;
        rst_tick();
        rst_tick();

        // Single launch on A/B/C with A re-pulsed while busy and in its done cycle;
        // C relaunched the cycle after its layer_done.
        clear_counts();
        for (int n = 0; n < 165; n++) begin
            s = '0;
            if (n == 0) s = 4'b0111;
            if (n == 5 || n == 28) s[0] = 1'b1;
            if (n == 77) s[2] = 1'b1;
            tick(s);
        end
        chk("A.addr_en_total", 32'(aen_cnt[0]), 32'd24);
        chk("A.result_count", 32'(rv_cnt[0]), 32'd4);
        chk("A.done_count", 32'(done_cnt[0]), 32'd1);
        for (int j = 0; j < 4; j++)
            chk($sformatf("A.idx%0d", j), (j < a_idx.size()) ? 32'(a_idx[j]) : 32'hFFFF_FFFF, 32'(j));
        chk("B.addr_en_total", 32'(aen_cnt[1]), 32'd1);
        chk("B.result_count", 32'(rv_cnt[1]), 32'd1);
        chk("C.addr_en_total", 32'(aen_cnt[2]), 32'd144);
        chk("C.result_count", 32'(rv_cnt[2]), 32'd24);
        chk("C.done_count", 32'(done_cnt[2]), 32'd2);

        // Reset in the middle of a layer, then a fresh launch on A.
        clear_counts();
        for (int n = 0; n < 60; n++) begin
            if (n == 12) begin
                rst_tick();
                clear_counts();
            end else begin
                s = '0;
                if (n == 0) s = 4'b1001;
                if (n == 20) s = 4'b0001;
                tick(s);
            end
        end
        chk("A.restart_results", 32'(rv_cnt[0]), 32'd4);
        chk("A.restart_idx0", (a_idx.size() > 0) ? 32'(a_idx[0]) : 32'hFFFF_FFFF, 32'd0);
        chk("D.after_reset_results", 32'(rv_cnt[3]), 32'd0);

        // Random launches and occasional resets on all configurations.
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 119) == 0) begin
                rst_tick();
            end else begin
                s = '0;
                for (int i = 0; i < 4; i++) if ($urandom_range(0, 5) == 0) s[i] = 1'b1;
                tick(s);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
